// File: rtl/shallow_fifo_rr_drain.sv
// Round-robin drain of NUM_QUEUES shallow FIFOs onto one valid/ready stream.
// Handshake: a word transfers on a rising edge where out_valid and out_ready are both high.
module shallow_fifo_rr_drain #(
   parameter int NUM_QUEUES = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int SRC_WIDTH  = (NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_QUEUES-1:0]            q_empty,
   output logic [NUM_QUEUES-1:0]            q_rd_en,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [SRC_WIDTH-1:0]             out_src,
   output logic                             out_last
);

   localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);
   localparam logic [SRC_WIDTH-1:0] LAST_Q   = SRC_WIDTH'(NUM_QUEUES - 1);
   localparam logic [SRC_WIDTH:0]   NQ_EXT   = (SRC_WIDTH + 1)'(NUM_QUEUES);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state, state_next;
   logic [SRC_WIDTH-1:0]   grant, grant_next;
   logic [SRC_WIDTH-1:0]   rr_ptr, rr_ptr_next;
   logic [CNT_WIDTH-1:0]   burst_cnt, burst_next;
   logic [NUM_QUEUES-1:0]  rot_ne;
   logic [SRC_WIDTH-1:0]   offset;
   logic [SRC_WIDTH:0]     found_sum;
   logic [SRC_WIDTH-1:0]   found_idx;
   logic                   found;
   logic [SRC_WIDTH-1:0]   grant_wrap;
   logic                   grant_empty;
   logic [DATA_WIDTH-1:0]  grant_data;
   logic                   load;
   logic                   pop;

   // Non-empty flags rotated so bit k is queue (rr_ptr + k) mod NUM_QUEUES.
   assign rot_ne = NUM_QUEUES'({~q_empty, ~q_empty} >> rr_ptr);

   always_comb begin
      found     = 1'b0;
      offset    = '0;
      found_sum = '0;
      found_idx = '0;
      for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
         if (rot_ne[k]) begin
            found  = 1'b1;
            offset = SRC_WIDTH'(k);
         end
      end
      found_sum = {1'b0, rr_ptr} + {1'b0, offset};
      if (found_sum >= NQ_EXT) found_sum = found_sum - NQ_EXT;
      found_idx = found_sum[SRC_WIDTH-1:0];
   end

   always_comb begin
      grant_empty = 1'b1;
      grant_data  = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (grant == SRC_WIDTH'(i)) begin
            grant_empty = q_empty[i];
            grant_data  = q_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign grant_wrap = (grant == LAST_Q) ? '0 : grant + 1'b1;
   assign load       = ~out_valid | out_ready;
   assign pop        = rst_n & (state == BURST) & load & ~grant_empty;

   always_comb begin
      q_rd_en = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         q_rd_en[i] = pop & (grant == SRC_WIDTH'(i));
      end
   end

   always_comb begin
      state_next  = state;
      grant_next  = grant;
      rr_ptr_next = rr_ptr;
      burst_next  = burst_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               grant_next = found_idx;
               burst_next = '0;
               state_next = BURST;
            end
         end
         BURST: begin
            // Without load the whole scheduler freezes, empty flags included.
            if (load) begin
               if (!grant_empty) begin
                  burst_next = burst_cnt + 1'b1;
                  if (burst_cnt == LAST_CNT) begin
                     state_next  = IDLE;
                     rr_ptr_next = grant_wrap;
                  end
               end else begin
                  state_next  = IDLE;
                  rr_ptr_next = grant_wrap;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         rr_ptr    <= rr_ptr_next;
         burst_cnt <= burst_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_src   <= grant;
         out_last  <= (burst_cnt == LAST_CNT);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shallow_fifo_rr_drain.sv
// Bench for shallow_fifo_rr_drain: FIFO models feed the DUT, a round-robin
// reference model fills an expected queue that every accepted word is checked against.
module tb_shallow_fifo_rr_drain;

   localparam int NQ = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int SW = 2;
   localparam int W  = 1 + SW + DW;

   logic            clk;
   logic            rst_n;
   logic [NQ-1:0]   q_empty;
   logic [NQ-1:0]   q_rd_en;
   logic [NQ*DW-1:0] q_rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_last;

   shallow_fifo_rr_drain #(
      .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .MAX_BURST(MB), .SRC_WIDTH(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_rd_en(q_rd_en),
      .q_rd_data(q_rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .out_last(out_last)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] fifo_q[NQ][$];
   logic [W-1:0]  exp_q[$];
   int            next_ptr = 0;
   logic          hold = 1'b0;
   logic [W-1:0]  hold_val = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NQ; i++) begin
         q_empty[i] = (fifo_q[i].size() == 0);
         q_rd_data[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : DW'($urandom);
      end
   endtask

   task automatic load_rand(input int q, input int n);
      for (int j = 0; j < n; j++) fifo_q[q].push_back(DW'($urandom));
   endtask

   // Reference: visit queues in circular order from the pointer, each non-empty
   // queue gives min(MB, remaining) words, the MB-th word of a grant is last.
   task automatic build_expected();
      int taken[NQ];
      int p;
      int q;
      int n;
      for (int i = 0; i < NQ; i++) taken[i] = 0;
      p = next_ptr;
      forever begin
         q = -1;
         for (int k = 0; k < NQ; k++) begin
            if (q < 0 && taken[(p + k) % NQ] < fifo_q[(p + k) % NQ].size()) q = (p + k) % NQ;
         end
         if (q < 0) break;
         n = fifo_q[q].size() - taken[q];
         if (n > MB) n = MB;
         for (int j = 0; j < n; j++)
            exp_q.push_back({(j == MB - 1), SW'(q), fifo_q[q][taken[q] + j]});
         taken[q] += n;
         p = (q + 1) % NQ;
         next_ptr = p;
      end
   endtask

   // One clock cycle: inputs are set after posedge, outputs sampled at negedge.
   task automatic tick(input logic rdy, output logic [NQ-1:0] rd);
      logic [W-1:0] cur;
      logic         ld;
      out_ready = rdy;
      @(negedge clk);
      rd  = q_rd_en;
      cur = {out_last, out_src, out_data};
      ld  = !out_valid || out_ready;
      check("rd_onehot", 64'($countones(rd) <= 1), 64'(1));
      check("rd_to_empty", 64'(rd & q_empty), 64'(0));
      if (!ld) check("rd_without_load", 64'(rd), 64'(0));
      if (hold) check("hold_stable", 64'(cur), 64'(hold_val));
      if (out_valid && out_ready) begin
         check("word_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) check("word", 64'(cur), 64'(exp_q.pop_front()));
      end
      hold     = out_valid && !out_ready;
      hold_val = cur;
      @(posedge clk);
      #1;
      for (int i = 0; i < NQ; i++)
         if (rd[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      drive_inputs();
   endtask

   task automatic drain(input logic rand_ready, input int limit, output int n);
      logic [NQ-1:0] rd;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick(rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, rd);
         n++;
      end
      check("drain_done", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      for (int k = 0; k < 3; k++) tick(1'b1, rd);
      check("settle_valid", 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [NQ-1:0] rd;
      logic [NQ-1:0] exp_rd[4];
      int n;

      // reset with random inputs
      rst_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
         q_empty   = NQ'($urandom);
         q_rd_data = $urandom;
         out_ready = 1'($urandom);
         #3;
         check("rst_valid", 64'(out_valid), 64'(0));
         check("rst_data", 64'(out_data), 64'(0));
         check("rst_src", 64'(out_src), 64'(0));
         check("rst_last", 64'(out_last), 64'(0));
         check("rst_rd_en", 64'(q_rd_en), 64'(0));
      end
      drive_inputs();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // fairness: 6 words each, 4 full grants then 4 short grants
      for (int i = 0; i < NQ; i++) load_rand(i, 6);
      drive_inputs();
      build_expected();
      drain(1'b0, 200, n);
      // 4 x (bubble + 4 pops) + 4 x (bubble + 2 pops + empty-detect cycle)
      check("fair_cycles", 64'(n), 64'(36));

      // single queue, cycle-exact read enables
      fifo_q[1].push_back(8'hA1);
      fifo_q[1].push_back(8'hA2);
      drive_inputs();
      build_expected();
      exp_rd[0] = 4'b0000; exp_rd[1] = 4'b0010; exp_rd[2] = 4'b0010; exp_rd[3] = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         tick(1'b1, rd);
         check("single_rd_en", 64'(rd), 64'(exp_rd[c]));
      end
      drain(1'b0, 50, n);

      // pointer continuity and wrap-around
      load_rand(0, 2); load_rand(2, 2);
      drive_inputs(); build_expected(); drain(1'b0, 50, n);
      load_rand(2, 1);
      drive_inputs(); build_expected(); drain(1'b0, 50, n);
      load_rand(0, 3); load_rand(3, 3);
      drive_inputs(); build_expected(); drain(1'b0, 50, n);

      // backpressure mid-burst
      load_rand(1, 4); load_rand(2, 2);
      drive_inputs(); build_expected();
      for (int c = 0; c < 3; c++) tick(1'b1, rd);
      for (int c = 0; c < 5; c++) begin
         tick(1'b0, rd);
         check("stall_rd_en", 64'(rd), 64'(0));
      end
      drain(1'b0, 50, n);

      // asynchronous reset mid-burst
      for (int i = 0; i < NQ; i++) load_rand(i, 3);
      drive_inputs(); build_expected();
      for (int c = 0; c < 3; c++) tick(1'b1, rd);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'(0));
      check("arst_data", 64'(out_data), 64'(0));
      check("arst_src", 64'(out_src), 64'(0));
      check("arst_last", 64'(out_last), 64'(0));
      check("arst_rd_en", 64'(q_rd_en), 64'(0));
      for (int i = 0; i < NQ; i++) fifo_q[i].delete();
      exp_q.delete();
      hold = 1'b0;
      next_ptr = 0;
      drive_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      load_rand(0, 2); load_rand(2, 2);
      drive_inputs(); build_expected(); drain(1'b0, 50, n);

      // randomized fills with random backpressure
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NQ; i++) load_rand(i, $urandom_range(0, 7));
         drive_inputs();
         build_expected();
         drain(1'b1, 1000, n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
